// File: rtl/lut_interp_stage.sv
// Piecewise-linear activation stage: slices x into LUT address/fraction, then interpolates base..next.
// Define INTERP_ROUND_EN for round-half-up interpolation; the default build floors.
module lut_interp_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FRAC_W = DATA_W - ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] lut_address,
    input  logic [DATA_W-1:0] lut_base,
    input  logic [DATA_W-1:0] lut_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int PROD_W = DATA_W + FRAC_W + 1;

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [FRAC_W-1:0] s1_frac;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_base;
    logic [DATA_W:0]   s2_diff;
    logic [FRAC_W-1:0] s2_frac;

    logic ld1, ld2, ld3;

    // Each stage may load when its downstream slot is empty or draining this cycle.
    assign ld3      = !out_valid || out_ready;
    assign ld2      = !s2_valid || ld3;
    assign ld1      = !s1_valid || ld2;
    assign in_ready = ld1;

    assign lut_address = s1_addr;

    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] frac_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_adj;
    logic signed [PROD_W-1:0] prod_sh;
    logic signed [PROD_W-1:0] base_ext;
    logic signed [PROD_W-1:0] sum;
    logic [DATA_W-1:0]        clamped;

`ifdef INTERP_ROUND_EN
    localparam logic signed [PROD_W-1:0] RND = PROD_W'(1) << (FRAC_W - 1);
`endif

    // Everything is widened to the product width so the add and clamp never wrap.
    always_comb begin
        diff_ext = {{FRAC_W{s2_diff[DATA_W]}}, s2_diff};
        frac_ext = {{(DATA_W+1){1'b0}}, s2_frac};
        prod     = diff_ext * frac_ext;
`ifdef INTERP_ROUND_EN
        prod_adj = prod + RND;
`else
        prod_adj = prod;
`endif
        prod_sh  = prod_adj >>> FRAC_W;
        base_ext = {{(FRAC_W+1){s2_base[DATA_W-1]}}, s2_base};
        sum      = base_ext + prod_sh;
        clamped  = sum[DATA_W-1:0];
        if (!sum[PROD_W-1] && (|sum[PROD_W-2:DATA_W-1])) begin
            clamped = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sum[PROD_W-1] && !(&sum[PROD_W-2:DATA_W-1])) begin
            clamped = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    // S1 keeps its address after the sample moves on, so lut_address only changes on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_frac  <= '0;
        end else if (ld1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_addr <= in_data[DATA_W-1 -: ADDR_W];
                s1_frac <= in_data[FRAC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_base  <= '0;
            s2_diff  <= '0;
            s2_frac  <= '0;
        end else if (ld2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_base <= lut_base;
                s2_diff <= {lut_next[DATA_W-1], lut_next} - {lut_base[DATA_W-1], lut_base};
                s2_frac <= s1_frac;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (ld3) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= clamped;
            end
        end
    end

endmodule
